// File: rtl/sel_inv_pipe.sv
// Channel select / optional invert feeding a DEPTH-stage valid/ready pipeline.
// Optional feature: define SEL_INV_PIPE_PARITY_EN to add q_par (even parity of q).
module sel_inv_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 2,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SELW-1:0]           sel,
  input  logic                      inv,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef SEL_INV_PIPE_PARITY_EN
  output logic                      q_par,
`endif
  output logic [WIDTH-1:0]          q
);

  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] vld_p;
  logic [DEPTH-1:0] adv;
  logic             adv_nxt;
  logic             take;
  logic [WIDTH-1:0] word_c;
`ifdef SEL_INV_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_p;
`endif

  // Unmatched select codes yield zero before the optional inversion.
  function automatic logic [WIDTH-1:0] pick_word(
    input logic [SELW-1:0]           s,
    input logic                      iv,
    input logic [CHANNELS*WIDTH-1:0] d
  );
    logic [WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (s == SELW'(k)) w = d[k*WIDTH +: WIDTH];
    end
    return w ^ {WIDTH{iv}};
  endfunction

  // Advance chain resolved from the output back to stage 0, so a full
  // pipeline can pop and push on the same edge.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = vld_p[DEPTH-1] && out_ready;
    adv_nxt        = adv[DEPTH-1];
    for (int i = DEPTH-2; i >= 0; i--) begin
      adv[i]  = vld_p[i] && (!vld_p[i+1] || adv_nxt);
      adv_nxt = adv[i];
    end
  end

  assign in_ready = !rst && (!vld_p[0] || adv[0]);
  assign take     = in_valid && in_ready;
  assign word_c   = pick_word(sel, inv, din);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) data_p[i] <= '0;
`ifdef SEL_INV_PIPE_PARITY_EN
      par_p <= '0;
`endif
    end else begin
      // stage 0: capture
      if (take) begin
        data_p[0] <= word_c;
        vld_p[0]  <= 1'b1;
`ifdef SEL_INV_PIPE_PARITY_EN
        par_p[0]  <= ^word_c;
`endif
      end else if (adv[0]) begin
        vld_p[0]  <= 1'b0;
      end
      // stages 1..DEPTH-1: shift forward
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i-1]) begin
          data_p[i] <= data_p[i-1];
          vld_p[i]  <= 1'b1;
`ifdef SEL_INV_PIPE_PARITY_EN
          par_p[i]  <= par_p[i-1];
`endif
        end else if (adv[i]) begin
          vld_p[i]  <= 1'b0;
        end
      end
    end
  end

  assign q         = data_p[DEPTH-1];
  assign out_valid = vld_p[DEPTH-1];
`ifdef SEL_INV_PIPE_PARITY_EN
  assign q_par     = par_p[DEPTH-1];
`endif

endmodule

// File: tb/tb_sel_inv_pipe.sv
// Scoreboard bench for sel_inv_pipe (WIDTH=8, CHANNELS=4, DEPTH=2).
module tb_sel_inv_pipe;
  localparam int WIDTH = 8;
  localparam int CHANNELS = 4;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic        inv;
  logic [31:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  q;
`ifdef SEL_INV_PIPE_PARITY_EN
  logic        q_par;
`endif

  sel_inv_pipe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .inv(inv), .din(din), .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef SEL_INV_PIPE_PARITY_EN
    .q_par(q_par),
`endif
    .q(q));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_q;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pop the scoreboard on each output handshake.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (out_valid === 1'b1 && prev_stall) check("hold_q", q, prev_q);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_out", {24'h0, q}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("q", q, e.w);
          if (e.lat) check("latency", cyc - e.acc, DEPTH);
`ifdef SEL_INV_PIPE_PARITY_EN
          check("q_par", q_par, ^e.w);
`endif
        end
      end
    end
    prev_stall = (rst !== 1'b1) && (out_valid === 1'b1) && (out_ready !== 1'b1);
    prev_q     = q;
  end

  // Called just after a rising edge; returns just after the capture edge.
  task automatic push(input logic [1:0] s, input logic iv, input logic [31:0] d,
                      input logic [7:0] w, input bit chk, input bit must);
    bit got;
    got = 0;
    in_valid = 1'b1; sel = s; inv = iv; din = d;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (n == 0 && must) check("in_ready_now", in_ready, 1);
      if (in_ready === 1'b1) begin
        sb.push_back('{w: w, acc: cyc, lat: chk});
        got = 1;
      end
    end
    if (!got) check("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; sel = 2'd0; inv = 1'b0; din = 32'h0; out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_q", q, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // select / invert
    push(2'd2, 1'b0, 32'hD4C3B2A1, 8'hC3, 1, 1);
    drain();
    push(2'd1, 1'b1, 32'hD4C3B2A1, 8'h4D, 1, 1);
    drain();
    push(2'd0, 1'b1, 32'hD4C3B2A1, 8'h5E, 1, 1);
    push(2'd3, 1'b0, 32'hD4C3B2A1, 8'hD4, 1, 1);
    drain();
    @(posedge clk); #1;

    // streaming 0x01..0x10 back to back
    for (int v = 1; v <= 16; v++) push(2'd0, 1'b0, v, 8'(v), 1, 1);
    drain();
    @(posedge clk); #1;

    // back-pressure
    out_ready = 1'b0;
    push(2'd1, 1'b0, 32'h0000_1100, 8'h11, 0, 1);
    push(2'd2, 1'b0, 32'h0022_0000, 8'h22, 0, 1);
    fork
      push(2'd3, 1'b0, 32'h3300_0000, 8'h33, 0, 0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_q", q, 8'h11);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    @(posedge clk); #1;

    // full pipeline: pop and push on the same edge
    out_ready = 1'b0;
    push(2'd0, 1'b0, 32'h0000_0041, 8'h41, 0, 1);
    push(2'd0, 1'b0, 32'h0000_0042, 8'h42, 0, 1);
    out_ready = 1'b1;
    push(2'd0, 1'b1, 32'h0000_0043, 8'hBC, 0, 1);
    drain();
    @(posedge clk); #1;

    // parity sample
    push(2'd0, 1'b0, 32'h0000_0007, 8'h07, 1, 1);
    push(2'd0, 1'b0, 32'h0000_0003, 8'h03, 1, 1);
    drain();
    @(posedge clk); #1;

    // mid-stream reset discards in-flight words
    out_ready = 1'b0;
    push(2'd0, 1'b0, 32'h0000_00E1, 8'hE1, 0, 1);
    push(2'd0, 1'b0, 32'h0000_00E2, 8'hE2, 0, 1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_q", q, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_empty", out_valid, 0);
    end
    @(posedge clk); #1;
    push(2'd2, 1'b0, 32'hD4C3B2A1, 8'hC3, 1, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
